div_sched: RTL and testbench

Run controller and tick scheduler for the codebase's clock-divide datapath: holds a programmable divide ratio, starts and stops the divider, and emits a one-cycle `tick` enable plus a divided `clock_f` level. It runs on the 1000 Hz system clock. It feeds the 1 Hz timekeeping and display logic. The block can be reconfigured between runs through a valid/ready handshake and supports periodic and one-shot operation.

---
 rtl/div_sched.sv | 111 +++++++++++
 tb/tb_div_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Divide-ratio run controller: counts system clocks up to a programmable ratio,
// and emits a one-cycle tick plus a divided clock level; periodic or one-shot.
module div_sched #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_div_i,
  input  logic             cfg_oneshot_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             busy_o,
  output logic             tick_o,
  output logic             clock_f_o,
  output logic             err_o,
  output logic [7:0]       tick_count_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             oneshot_q, oneshot_d;
  logic             tick_q, tick_d;
  logic             clock_f_q, clock_f_d;
  logic             err_q, err_d;
  logic [7:0]       tick_count_q, tick_count_d;

  logic xfer, term, running;

  assign xfer    = cfg_valid_i && (state_q == S_IDLE);
  assign term    = (cnt_q == div_q - WIDTH'(1));
  assign running = (state_q == S_RUN) && !stop_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A config transfer and a start on the same edge: config wins, start is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i && !xfer) state_d = S_RUN;
      S_RUN:  if (stop_i || (term && oneshot_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == S_RUN);
    cfg_ready_o = (state_q == S_IDLE);
  end

  always_comb begin
    div_d        = div_q;
    oneshot_d    = oneshot_q;
    err_d        = err_q;
    cnt_d        = '0;
    tick_d       = 1'b0;
    clock_f_d    = 1'b0;
    tick_count_d = tick_count_q;
    if (xfer) begin
      if (cfg_div_i >= WIDTH'(2)) begin
        div_d     = cfg_div_i;
        oneshot_d = cfg_oneshot_i;
        err_d     = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (state_q == S_IDLE && state_d == S_RUN) tick_count_d = '0;
    if (running) begin
      cnt_d  = term ? '0 : cnt_q + WIDTH'(1);
      tick_d = term;
      if (term) tick_count_d = tick_count_q + 8'd1;
    end
    // clock_f follows cnt one cycle late; forced low whenever we land in IDLE
    if (running && state_d == S_RUN) clock_f_d = (cnt_q >= (div_q >> 1));
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_q        <= WIDTH'(DEFAULT_DIV);
      oneshot_q    <= 1'b0;
      cnt_q        <= '0;
      tick_q       <= 1'b0;
      clock_f_q    <= 1'b0;
      err_q        <= 1'b0;
      tick_count_q <= '0;
    end else begin
      div_q        <= div_d;
      oneshot_q    <= oneshot_d;
      cnt_q        <= cnt_d;
      tick_q       <= tick_d;
      clock_f_q    <= clock_f_d;
      err_q        <= err_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign tick_o       = tick_q;
  assign clock_f_o    = clock_f_q;
  assign err_o        = err_q;
  assign tick_count_o = tick_count_q;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: stimulus queues expected ticks (cycle, count),
// a negedge monitor pops and compares each tick the DUT raises.
module tb_div_sched;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cfg_valid = 1'b0, cfg_ready, cfg_oneshot = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         start = 1'b0, stop = 1'b0;
  logic         busy, tick, clock_f, err;
  logic [7:0]   tick_count;

  typedef struct { int cyc; int cnt; } exp_t;
  exp_t exp_q[$];

  int vectors = 0, miscompares = 0, cyc = 0;

  div_sched #(.WIDTH(W), .DEFAULT_DIV(1000)) dut (
    .clock_i(clk), .reset_i(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_div_i(cfg_div), .cfg_oneshot_i(cfg_oneshot),
    .start_i(start), .stop_i(stop),
    .busy_o(busy), .tick_o(tick), .clock_f_o(clock_f),
    .err_o(err), .tick_count_o(tick_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every tick must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && tick) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || int'(tick_count) != e.cnt) begin
          miscompares++;
          $display("FAIL tick: got cycle %0d count %0d, expected cycle %0d count %0d",
                   cyc, tick_count, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int div, input logic os);
    cfg_valid = 1'b1; cfg_div = W'(div); cfg_oneshot = os;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic start_run(output int s);
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic push_tick(input int c, input int n);
    exp_t e;
    e.cyc = c; e.cnt = n;
    exp_q.push_back(e);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int s;
    logic [3:0] pat4;
    logic [4:0] pat5;
    pat4 = 4'b1100;
    pat5 = 5'b11100;

    // Reset state
    step(2);
    check("rst_busy", busy, 0);
    check("rst_tick", tick, 0);
    check("rst_clock_f", clock_f, 0);
    check("rst_err", err, 0);
    check("rst_tick_count", tick_count, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    step();

    // div=4 periodic: ticks at +4,+8,+12, clock_f 0,0,1,1
    cfg(4, 1'b0);
    check("cfg4_err", err, 0);
    start_run(s);
    check("run4_busy", busy, 1);
    check("run4_cfg_ready", cfg_ready, 0);
    for (int k = 1; k <= 3; k++) push_tick(s + 4 * k, k);
    for (int k = 1; k <= 12; k++) begin
      step();
      check("clock_f_div4", clock_f, int'(pat4[(k - 1) % 4]));
    end
    check("tick_count_3", tick_count, 3);
    do_stop();
    check("stop4_busy", busy, 0);
    check("stop4_clock_f", clock_f, 0);
    check("stop4_tick_count", tick_count, 3);

    // div=5 periodic: low 2, high 3
    cfg(5, 1'b0);
    start_run(s);
    check("start_clears_count", tick_count, 0);
    for (int k = 1; k <= 2; k++) push_tick(s + 5 * k, k);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("clock_f_div5", clock_f, int'(pat5[(k - 1) % 5]));
    end
    do_stop();

    // div=3 one-shot: single tick at +3, busy drops on that edge
    cfg(3, 1'b1);
    start_run(s);
    push_tick(s + 3, 1);
    step(2);
    check("os_busy_before", busy, 1);
    step();
    check("os_busy_after", busy, 0);
    check("os_cfg_ready", cfg_ready, 1);
    check("os_clock_f", clock_f, 0);
    check("os_tick_count", tick_count, 1);
    step(5);
    check("os_idle_clock_f", clock_f, 0);
    check("os_hold_count", tick_count, 1);

    // Rejected config keeps div=4 periodic; stop on terminal count suppresses tick
    cfg(4, 1'b0);
    cfg(1, 1'b1);
    check("cfg1_err", err, 1);
    start_run(s);
    push_tick(s + 4, 1);
    push_tick(s + 8, 2);
    step(4);
    cfg_valid = 1'b1; cfg_div = W'(7);
    check("run_cfg_ready", cfg_ready, 0);
    step();
    cfg_valid = 1'b0;
    check("run_cfg_err_held", err, 1);
    step(6);
    do_stop();
    check("stop_tc_busy", busy, 0);
    check("stop_tc_count", tick_count, 2);
    check("stop_tc_tick", tick, 0);
    cfg(2, 1'b0);
    check("cfg2_err_clear", err, 0);

    // 256 ticks at div=2 wraps the counter
    start_run(s);
    for (int k = 1; k <= 256; k++) push_tick(s + 2 * k, k % 256);
    step(512);
    check("wrap_count", tick_count, 0);
    do_stop();

    // Async reset mid-run at cnt=2, then default ratio of 1000
    cfg(4, 1'b0);
    start_run(s);
    step(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfg_ready", cfg_ready, 1);
    check("mid_rst_clock_f", clock_f, 0);
    check("mid_rst_tick", tick, 0);
    rst_n = 1'b1;
    start_run(s);
    push_tick(s + 1000, 1);
    step(999);
    check("default_pre_tick", tick_count, 0);
    step();
    check("default_tick", tick_count, 1);
    do_stop();

    step(3);
    check("pending_ticks", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
